// File: rtl/deconcat_pkg.sv
// deconcat_pkg
// Shared definitions for the streaming deconcatenator:
//   - acc_state_e     : accumulator states (COLLECT while beats arrive, FULL
//                       while a complete line waits for the output register)
//   - calc_len_encode : pattern code width for a given number of patterns
//   - calc_n_words    : permutation granules per line
//   - calc_beats      : input beats per line
//   - calc_cnt_w      : beat counter width (at least one bit)
//   - xor_index       : source word index for the XOR scan permutation
package deconcat_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } acc_state_e;

    function automatic int calc_len_encode(input int num_patterns);
        return (num_patterns > 1) ? $clog2(num_patterns) : 1;
    endfunction

    function automatic int calc_n_words(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    function automatic int calc_beats(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Masking with n_words-1 keeps the index inside the line even when the
    // pattern is out of range; that branch is never selected in that case,
    // but the read must stay in bounds.
    function automatic int unsigned xor_index(input int unsigned j,
                                              input int unsigned pattern,
                                              input int unsigned n_words);
        return (j ^ pattern) & (n_words - 1);
    endfunction

endpackage

// File: rtl/deconcat_stream_permute.sv
// word_permute
// Purely combinational word scan permutation.
//   line         in  LINE_W      assembled line
//   pattern      in  LEN_ENCODE  pattern code of the line
//   permuted     out LINE_W      word j = line word (j XOR pattern), or the
//                                line unchanged when the pattern is out of range
//   out_of_range out 1           pattern >= number of words in the line
module word_permute
    import deconcat_pkg::*;
#(
    parameter int LINE_W     = 256,
    parameter int WORD_W     = 32,
    parameter int LEN_ENCODE = 3
) (
    input  logic [LINE_W-1:0]     line,
    input  logic [LEN_ENCODE-1:0] pattern,
    output logic [LINE_W-1:0]     permuted,
    output logic                  out_of_range
);

    localparam int N_WORDS = calc_n_words(LINE_W, WORD_W);

    // An out-of-range pattern has no defined permutation, so the line is
    // passed through untouched and the flag lets the caller report it.
    always_comb begin
        out_of_range = (32'(pattern) >= 32'(N_WORDS));
        permuted     = line;
        if (!out_of_range) begin
            for (int j = 0; j < N_WORDS; j++) begin
                permuted[j*WORD_W +: WORD_W] =
                    line[xor_index(j, 32'(pattern), N_WORDS)*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/deconcat_stream.sv
// deconcat_stream
// Collects one compressed line as BEATS input beats, applies the
// pattern-selected word scan permutation and presents the result on a
// valid/ready output. The accumulator and the output register form a double
// buffer, so a new line can be collected while the previous one is stalled.
//   clk          in  1           clock
//   rst_n        in  1           synchronous active-low reset
//   in_valid_i   in  1           beat valid
//   in_ready_o   out 1           beat accepted when valid && ready
//   in_data_i    in  BEAT_W      beat k fills line bits [k*BEAT_W +: BEAT_W]
//   in_pattern_i in  LEN_ENCODE  pattern code, sampled on beat 0 only
//   in_last_i    in  1           sender's end-of-line marker
//   out_valid_o  out 1           scanned line valid
//   out_ready_i  in  1           downstream accept
//   scanned_o    out LINE_W      permuted line
//   pattern_o    out LEN_ENCODE  pattern of the presented line
//   err_o        out 1           framing or pattern error, qualified by out_valid_o
module deconcat_stream
    import deconcat_pkg::*;
#(
    parameter int LINE_W       = 256,
    parameter int BEAT_W       = 64,
    parameter int WORD_W       = 32,
    parameter int NUM_PATTERNS = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [BEAT_W-1:0]                        in_data_i,
    input  logic [calc_len_encode(NUM_PATTERNS)-1:0] in_pattern_i,
    input  logic                                     in_last_i,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [LINE_W-1:0]                        scanned_o,
    output logic [calc_len_encode(NUM_PATTERNS)-1:0] pattern_o,
    output logic                                     err_o
);

    localparam int LEN_ENCODE = calc_len_encode(NUM_PATTERNS);
    localparam int BEATS      = calc_beats(LINE_W, BEAT_W);
    localparam int CNT_W      = calc_cnt_w(BEATS);

    acc_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0]       acc_q;
    logic [LEN_ENCODE-1:0]   pat_q;
    logic                    frame_err_q;

    logic                    beat_accept;
    logic                    last_beat;
    logic                    frame_bad;
    logic                    transfer;
    logic [LINE_W-1:0]       permuted_line;
    logic                    pattern_err;

    // Ready comes straight from the state register, so there is no
    // combinational path from out_ready_i to in_ready_o.
    assign in_ready_o  = (state_q == COLLECT);
    assign beat_accept = in_valid_i && in_ready_o;
    assign last_beat   = (cnt_q == CNT_W'(BEATS - 1));
    assign frame_bad   = (in_last_i != last_beat);
    assign transfer    = (state_q == FULL) && (!out_valid_o || out_ready_i);

    // Accumulator state and beat counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The line always closes on the counter, never on in_last_i; the counter
    // parks at BEATS-1 while FULL and only wraps when the line is handed over.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            COLLECT: begin
                if (beat_accept) begin
                    if (last_beat) begin
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (transfer) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // Beat capture. Beat 0 latches the pattern and restarts the sticky
    // framing error; later beats can only add to it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            pat_q       <= '0;
            frame_err_q <= 1'b0;
        end else if (beat_accept) begin
            acc_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= in_data_i;
            if (cnt_q == '0) begin
                pat_q       <= in_pattern_i;
                frame_err_q <= frame_bad;
            end else begin
                frame_err_q <= frame_err_q | frame_bad;
            end
        end
    end

    word_permute #(
        .LINE_W     (LINE_W),
        .WORD_W     (WORD_W),
        .LEN_ENCODE (LEN_ENCODE)
    ) u_permute (
        .line         (acc_q),
        .pattern      (pat_q),
        .permuted     (permuted_line),
        .out_of_range (pattern_err)
    );

    // Output register: a transfer loads new data (even while the old line is
    // being drained), otherwise a handshake empties it and data stays put.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            scanned_o   <= '0;
            pattern_o   <= '0;
            err_o       <= 1'b0;
        end else if (transfer) begin
            out_valid_o <= 1'b1;
            scanned_o   <= permuted_line;
            pattern_o   <= pat_q;
            err_o       <= frame_err_q | pattern_err;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deconcat_stream.sv
// tb_deconcat_stream
// Self-checking bench for deconcat_stream with 256-bit lines, 64-bit beats,
// 32-bit words and 16 pattern codes (so codes 8..15 are out of range).
module tb_deconcat_stream;

    localparam int LINE_W       = 256;
    localparam int BEAT_W       = 64;
    localparam int WORD_W       = 32;
    localparam int NUM_PATTERNS = 16;
    localparam int BEATS        = 4;
    localparam int N_WORDS      = 8;
    localparam int N_RAND       = 40;

    localparam logic [255:0] W_LINE =
        256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [3:0]   in_pattern;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] scanned;
    logic [3:0]   pattern_out;
    logic         err;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [255:0] line;
        logic [3:0]   pattern;
        int           last_pos;
        logic [255:0] exp_scanned;
        logic         exp_err;
    } vec_t;

    typedef struct {
        logic [255:0] scanned;
        logic [3:0]   pattern;
        logic         err;
    } exp_t;

    vec_t vecs[5];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    deconcat_stream #(
        .LINE_W       (LINE_W),
        .BEAT_W       (BEAT_W),
        .WORD_W       (WORD_W),
        .NUM_PATTERNS (NUM_PATTERNS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_pattern_i (in_pattern),
        .in_last_i    (in_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .scanned_o    (scanned),
        .pattern_o    (pattern_out),
        .err_o        (err)
    );

    // Hang guard: ends the run if something waits forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: word j of the scanned line is word (j XOR pattern) of the
    // assembled line when the pattern addresses a word, otherwise the line
    // passes unchanged. Any in_last placement other than the final beat, or
    // an out-of-range pattern, flags the line.
    function automatic exp_t model_line(input logic [255:0] line,
                                        input logic [3:0] pattern,
                                        input int last_pos);
        logic [31:0] words[N_WORDS];
        exp_t e;
        for (int i = 0; i < N_WORDS; i++) words[i] = line[i*32 +: 32];
        e.scanned = '0;
        for (int j = 0; j < N_WORDS; j++) begin
            if (int'(pattern) < N_WORDS) e.scanned[j*32 +: 32] = words[j ^ int'(pattern)];
            else                         e.scanned[j*32 +: 32] = words[j];
        end
        e.pattern = pattern;
        e.err     = (last_pos != BEATS - 1) || (int'(pattern) >= N_WORDS);
        return e;
    endfunction

    // Sends one line; in_last is raised only on beat last_pos (4 = never).
    // Non-first beats carry a random pattern code that must be ignored.
    task automatic applyStimulus(input logic [255:0] line, input logic [3:0] pattern,
                                 input int last_pos, input int max_gap);
        int gap;
        int budget;
        for (int k = 0; k < BEATS; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) tick();
            in_valid   = 1'b1;
            in_data    = line[k*64 +: 64];
            in_pattern = (k == 0) ? pattern : 4'($urandom);
            in_last    = (k == last_pos);
            budget     = 0;
            while (!in_ready && budget < 200) begin
                tick();
                budget++;
            end
            if (!in_ready) begin
                checkOutput("in_ready_timeout", 256'(in_ready), 256'(1));
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts cycles from the cycle in which the final beat was accepted,
    // so a value of 2 means out_valid is seen one edge after the accept edge.
    task automatic wait_out_valid(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 60) begin
            tick();
            cycles++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 256'(out_valid), 256'(1));
    endtask

    initial begin
        int   lat;
        int   n_out;
        exp_t ea;
        exp_t eb;
        logic [255:0] la;
        logic [255:0] lb;

        vecs[0] = '{{64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
                     64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000},
                    4'd0, 3,
                    {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
                     64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000},
                    1'b0};
        vecs[1] = '{W_LINE, 4'd5, 3,
                    256'h22222222_33333333_00000000_11111111_66666666_77777777_44444444_55555555,
                    1'b0};
        vecs[2] = '{W_LINE, 4'd2, 1,
                    256'h55555555_44444444_77777777_66666666_11111111_00000000_33333333_22222222,
                    1'b1};
        vecs[3] = '{W_LINE, 4'd0, 3, W_LINE, 1'b0};
        vecs[4] = '{W_LINE, 4'd9, 3, W_LINE, 1'b1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_pattern = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        checkOutput("reset_in_ready", 256'(in_ready), 256'(1));
        checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_scanned", scanned, 256'(0));
        checkOutput("reset_pattern", 256'(pattern_out), 256'(0));
        checkOutput("reset_err", 256'(err), 256'(0));

        // Directed table: identity, pattern 5, framing error, clean line
        // after the error, out-of-range pattern.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].line, vecs[i].pattern, vecs[i].last_pos, 0);
            checkOutput($sformatf("vec%0d_valid_early", i), 256'(out_valid), 256'(0));
            wait_out_valid(lat);
            checkOutput($sformatf("vec%0d_latency", i), 256'(lat), 256'(2));
            checkOutput($sformatf("vec%0d_scanned", i), scanned, vecs[i].exp_scanned);
            checkOutput($sformatf("vec%0d_pattern", i), 256'(pattern_out), 256'(vecs[i].pattern));
            checkOutput($sformatf("vec%0d_err", i), 256'(err), 256'(vecs[i].exp_err));
            tick();
        end

        // Backpressure: line A held while line B fills the accumulator.
        out_ready = 1'b0;
        la = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        lb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ea = model_line(la, 4'd0, 3);
        eb = model_line(lb, 4'd3, 3);
        applyStimulus(la, 4'd0, 3, 0);
        wait_out_valid(lat);
        applyStimulus(lb, 4'd3, 3, 0);
        checkOutput("bp_hold_a_first", scanned, ea.scanned);
        tick();
        tick();
        checkOutput("bp_full_ready", 256'(in_ready), 256'(0));
        checkOutput("bp_hold_valid", 256'(out_valid), 256'(1));
        checkOutput("bp_hold_a_later", scanned, ea.scanned);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_b_valid", 256'(out_valid), 256'(1));
        checkOutput("bp_b_scanned", scanned, eb.scanned);
        checkOutput("bp_b_pattern", 256'(pattern_out), 256'(3));
        checkOutput("bp_ready_again", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        tick();
        checkOutput("bp_drained", 256'(out_valid), 256'(0));

        // Reset with an output held and two beats of a new line collected.
        out_ready = 1'b0;
        applyStimulus(la, 4'd1, 3, 0);
        wait_out_valid(lat);
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 64'hDEAD_BEEF_0000_0000;
        tick();
        in_data  = 64'hDEAD_BEEF_0000_0001;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rst_mid_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_mid_in_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        eb = model_line(lb, 4'd6, 3);
        applyStimulus(lb, 4'd6, 3, 0);
        n_out = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                n_out++;
                if (n_out == 1) begin
                    checkOutput("rst_fresh_scanned", scanned, eb.scanned);
                    checkOutput("rst_fresh_err", 256'(err), 256'(eb.err));
                end
            end
            tick();
        end
        checkOutput("rst_fresh_count", 256'(n_out), 256'(1));

        // Random lines with gaps, random backpressure and occasional framing
        // errors, checked in order against the reference model.
        out_ready = 1'b0;
        exp_q.delete();
        fork
            begin
                logic [255:0] line;
                logic [3:0]   pat;
                int           last_pos;
                for (int i = 0; i < N_RAND; i++) begin
                    line = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
                    pat  = 4'($urandom_range(15, 0));
                    last_pos = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 0)) : 3;
                    exp_q.push_back(model_line(line, pat, last_pos));
                    applyStimulus(line, pat, last_pos, 2);
                end
            end
            begin
                int   got;
                int   cyc;
                exp_t e;
                got = 0;
                cyc = 0;
                while (got < N_RAND && cyc < 5000) begin
                    out_ready = ($urandom_range(3, 0) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("rand_unexpected_line", 256'(1), 256'(0));
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput($sformatf("rand%0d_scanned", got), scanned, e.scanned);
                            checkOutput($sformatf("rand%0d_pattern", got), 256'(pattern_out), 256'(e.pattern));
                            checkOutput($sformatf("rand%0d_err", got), 256'(err), 256'(e.err));
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
                if (got < N_RAND) checkOutput("rand_timeout", 256'(got), 256'(N_RAND));
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/deconcat_stream.md
Name: deconcat_stream

Overview:
- Streaming, parametrised successor to the single-cycle deconcatenator in the decompressor path.
- Accepts one compressed-line payload as BEATS = LINE_W/BEAT_W beats over a valid/ready interface, with the pattern code sampled on the first beat.
- Reassembles the line and applies the pattern-selected word scan permutation.
- Presents the scanned line on a valid/ready output. The accumulator and output register form a double buffer, so a new line can be collected while the previous one is stalled downstream.

Parameters:
- LINE_W, 256, scanned line width in bits.
- BEAT_W, 64, input beat width; LINE_W % BEAT_W == 0.
- WORD_W, 32, permutation granule; N_WORDS = LINE_W/WORD_W, which must be a power of two.
- NUM_PATTERNS, 8, number of pattern codes; LEN_ENCODE = $clog2(NUM_PATTERNS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o.
- in_data_i  in  BEAT_W  payload beat; beat k fills line bits [k*BEAT_W +: BEAT_W].
- in_pattern_i  in  LEN_ENCODE  pattern code; sampled only on beat 0.
- in_last_i  in  1  sender's end-of-line marker.
- out_valid_o  out  1  scanned line valid.
- out_ready_i  in  1  downstream accept.
- scanned_o  out  LINE_W  permuted line.
- pattern_o  out  LEN_ENCODE  pattern of the presented line.
- err_o  out  1  framing or pattern error for the presented line; qualified by out_valid_o.

Behaviour:
- One clock domain. The clock and reset are named clk and rst_n; reset is synchronous and active-low.
- Reset values: in_ready_o=1, out_valid_o=0, scanned_o=0, pattern_o=0, err_o=0. Beat counter=0, accumulator state=COLLECT.
- Accumulator FSM:
  - COLLECT: count beats 0..BEATS-1 and write each beat into the accumulator. On beat 0, latch the pattern and clear the sticky error.
  - Framing error: in_last_i differs from (cnt==BEATS-1) on any accepted beat. This sets the sticky error. The line always closes at cnt==BEATS-1 regardless of in_last_i.
  - Pattern error: a latched pattern >= N_WORDS sets the error.
  - After the final beat: go to FULL.
  - FULL: in_ready_o=0. Transfer to the output register when the output register is empty, or is being drained in the same cycle (out_valid_o && out_ready_i). After transfer, return to COLLECT with cnt=0.
- in_ready_o = (state==COLLECT). It is registered, with no combinational path from out_ready_i.
- Transfer:
  - out_valid_o rises on the cycle after entering FULL when the output is empty, giving 2 cycles from the final-beat accept edge to out_valid_o.
  - Back-to-back lines with out_ready_i=1 sustain one line per BEATS+1 cycles.
- Permutation: scanned word j = accumulator word (j XOR pattern) for j in 0..N_WORDS-1. Pattern 0 is identity. If the pattern error is set, the line is passed unpermuted and err_o=1.
- Output register:
  - Holds scanned_o, pattern_o and err_o stable while out_valid_o && !out_ready_i.
  - out_valid_o clears on handshake unless a transfer loads in the same cycle, in which case it stays 1 with new data.
- Reset mid-operation discards any partial line and any held output; no residue survives, and the next beat is treated as beat 0.
- The counter wraps only via the transfer. It never exceeds BEATS-1.

Decomposition:
- Package deconcat_pkg:
  - LEN_ENCODE and N_WORDS/BEATS derivation functions.
  - The state enum (COLLECT, FULL).
  - A function or macro for word-index XOR.
- Sub-module word_permute: purely combinational. Inputs are the line and the pattern; outputs are the permuted line and the pattern-out-of-range flag. It is instantiated once, between the accumulator and the output register.

Test Plan:
- Identity line: 4 beats 0x...00/01/02/03 (each beat's low byte = beat index), pattern 0, out_ready_i=1, in_last_i on beat 3.
  - scanned_o equals the concatenation, pattern_o=0, err_o=0.
  - out_valid_o asserts 2 cycles after beat 3 is accepted.
- Pattern 5, words preloaded w_i = 0x1111_1111*i.
  - scanned word j = w_(j^5); e.g. word 0 = 0x5555_5555 and word 7 = 0x2222_2222.
- Backpressure: out_ready_i=0 while two lines are sent.
  - Line 1 is held stable.
  - Line 2 fills, then in_ready_o=0 (FULL).
  - After out_ready_i=1 for one cycle, line 2 appears on the next cycle with no beat lost; then in_ready_o=1.
- Framing error: in_last_i asserted on beat 1, with valid pattern 2.
  - The line still closes after beat 3, and err_o=1 with the line permuted.
  - The following clean line has err_o=0.
- Out-of-range pattern: NUM_PATTERNS=16, N_WORDS=8, pattern 9.
  - Unpermuted passthrough, err_o=1, pattern_o=9.
- Reset after 2 beats (rst_n=0 for 1 cycle) with an output held.
  - out_valid_o=0 and in_ready_o=1.
  - A fresh 4-beat line then produces exactly one correct output.
